// File: rtl/trs80_audio_pkg.sv
// Shared types and constants for the TRS-80 / CoCo audio back-end.
package trs80_audio_pkg;

  // Sample pipeline sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    FILT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Unsigned midpoint of the 12-bit sound word; maps to PCM zero.
  localparam logic [11:0] MID = 12'd2048;

  // Amount the 1-bit sound line adds to the mix when high.
  localparam logic [11:0] DEF_SND_LEVEL = 12'h400;

endpackage

// File: rtl/trs80_audio_out_if.sv
// Sample-side bus between the sound-select block and the audio back-end.
interface trs80_audio_out_if;
  logic               ce_sample;
  logic        [11:0] sound;
  logic               snd;
  logic               mute;
  logic signed [15:0] pcm;
  logic               pcm_valid;

  // Upstream side: offers samples, sees the filtered result.
  modport master (
    output ce_sample, sound, snd, mute,
    input  pcm, pcm_valid
  );

  // Audio back-end side.
  modport slave (
    input  ce_sample, sound, snd, mute,
    output pcm, pcm_valid
  );
endinterface

// File: rtl/trs80_sigma_delta.sv
// First-order sigma-delta modulator: the carry out of an offset-binary
// accumulator gives a bitstream whose density tracks (pcm + 32768) / 65536.
module trs80_sigma_delta (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] pcm,
  output logic               dac_out
);

  logic [15:0] acc;
  logic [16:0] sum;

  // Flipping the sign bit turns two's-complement into offset binary.
  assign sum = {1'b0, acc} + {1'b0, pcm ^ 16'h8000};

  // Accumulate every clock and emit the carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      acc     <= sum[15:0];
      dac_out <= sum[16];
    end
  end

endmodule

// File: rtl/trs80_audio_out.sv
// Audio back-end: captures a sound sample on a strobe, mixes in the 1-bit
// sound line with saturation, low-pass filters it, and publishes signed PCM
// plus a sigma-delta bitstream for the pin-level RC DAC.
module trs80_audio_out
  import trs80_audio_pkg::*;
#(
  parameter int          FILTER_SHIFT = 3,
  parameter logic [11:0] SND_LEVEL    = DEF_SND_LEVEL
) (
  input  logic                    clk,
  input  logic                    reset_n,
  trs80_audio_out_if.slave        bus,
  output logic                    dac_out
);

  state_t state, state_nxt;

  logic        [11:0] sound_r;
  logic               snd_r;
  logic               mute_r;
  logic signed [15:0] x_r;
  logic signed [15:0] lp;
  logic signed [15:0] pcm_r;
  logic               pcm_valid_r;

  logic        [12:0] mix_sum;
  logic        [11:0] mix;
  logic signed [15:0] x_c;
  logic signed [16:0] diff;
  logic signed [16:0] step;

  // Sequencer next-state: strobes outside IDLE are simply ignored.
  always_comb begin
    // NOTE: next state defaults to the current one first so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ce_sample) state_nxt = MIX;
      MIX:     state_nxt = FILT;
      FILT:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: all registered state uses non-blocking assignment so every flop sees pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Mix, saturate, mute, then re-centre to signed and scale to 16 bits.
  always_comb begin
    mix_sum = {1'b0, sound_r} + (snd_r ? {1'b0, SND_LEVEL} : 13'd0);
    mix     = mix_sum[12] ? 12'hFFF : mix_sum[11:0];
    if (mute_r) mix = MID;
    // mix - 2048 is mix with its MSB inverted, read as 12-bit signed.
    x_c     = {~mix[11], mix[10:0], 4'b0000};
  end

  // One-pole IIR step; 17 bits keep the difference from wrapping.
  always_comb begin
    diff = {x_r[15], x_r} - {lp[15], lp};
    step = diff >>> FILTER_SHIFT;
  end

  // Datapath registers advanced by the sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sound_r     <= '0;
      snd_r       <= 1'b0;
      mute_r      <= 1'b0;
      x_r         <= '0;
      lp          <= '0;
      pcm_r       <= '0;
      pcm_valid_r <= 1'b0;
    end else begin
      pcm_valid_r <= 1'b0;
      case (state)
        IDLE: if (bus.ce_sample) begin
          sound_r <= bus.sound;
          snd_r   <= bus.snd;
          mute_r  <= bus.mute;
        end
        MIX:  x_r <= x_c;
        FILT: lp  <= 16'(lp + step);
        OUT: begin
          pcm_r       <= lp;
          pcm_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pcm       = pcm_r;
  assign bus.pcm_valid = pcm_valid_r;

  trs80_sigma_delta u_sigma_delta (
    .clk     (clk),
    .reset_n (reset_n),
    .pcm     (pcm_r),
    .dac_out (dac_out)
  );

endmodule

// File: tb/tb_trs80_audio_out.sv
// Bench for trs80_audio_out: two instances (filter bypass and shift 3)
// driven with identical stimulus and checked against hand-computed vectors
// and an arithmetic reference model.
module tb_trs80_audio_out;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dac0, dac3;

  int n_checks = 0;
  int n_errors = 0;
  int lp0_m = 0;
  int lp3_m = 0;

  trs80_audio_out_if if0 ();
  trs80_audio_out_if if3 ();

  trs80_audio_out #(.FILTER_SHIFT(0), .SND_LEVEL(12'h400)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave), .dac_out(dac0)
  );

  trs80_audio_out #(.FILTER_SHIFT(3), .SND_LEVEL(12'h400)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3.slave), .dac_out(dac3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        [11:0] sound;
    logic               snd;
    logic               mute;
    logic signed [15:0] exp0;
    logic signed [15:0] exp3;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: mix, saturate, mute, centre, then a floor-divided IIR step.
  function automatic int model_step(input int lp, input int s, input bit sn,
                                    input bit m, input int sh);
    int mixv, x, d, q, div;
    mixv = s + (sn ? 1024 : 0);
    if (mixv > 4095) mixv = 4095;
    if (m) mixv = 2048;
    x   = (mixv - 2048) * 16;
    d   = x - lp;
    div = 1 << sh;
    if (d >= 0) q = d / div;
    else        q = -((-d + div - 1) / div);
    return lp + q;
  endfunction

  task automatic drive(input logic ce, input logic [11:0] s, input logic sn, input logic m);
    if0.ce_sample = ce; if0.sound = s; if0.snd = sn; if0.mute = m;
    if3.ce_sample = ce; if3.sound = s; if3.snd = sn; if3.mute = m;
  endtask

  // One strobe; inputs are scrambled right after acceptance. Expect a single
  // pulse on the 4th negedge (between E3 and E4) carrying the expected pcm.
  task automatic run_sample(input logic [11:0] s, input logic sn, input logic m,
                            input string tag, input int exp0, input int exp3);
    int p0 = 0, p3 = 0, at0 = 0, at3 = 0, g0 = 0, g3 = 0;
    drive(1'b1, s, sn, m);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 12'($urandom), 1'($urandom), 1'($urandom));
      if (if0.pcm_valid) begin p0++; at0 = c; g0 = if0.pcm; end
      if (if3.pcm_valid) begin p3++; at3 = c; g3 = if3.pcm; end
    end
    check({tag, "/pulses0"}, p0, 1);
    check({tag, "/pulse_at0"}, at0, 4);
    check({tag, "/pcm0"}, g0, exp0);
    check({tag, "/pulses3"}, p3, 1);
    check({tag, "/pulse_at3"}, at3, 4);
    check({tag, "/pcm3"}, g3, exp3);
  endtask

  task automatic count_pulses(input int cycles, output int c0, output int c3);
    c0 = 0; c3 = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (if0.pcm_valid) c0++;
      if (if3.pcm_valid) c3++;
    end
  endtask

  initial begin
    int c0, c3, ones, expd;

    vecs[0] = '{12'h800, 1'b1, 1'b0, 16'sh4000, 16'sh0800};
    vecs[1] = '{12'h800, 1'b1, 1'b0, 16'sh4000, 16'sh0F00};
    vecs[2] = '{12'hFFF, 1'b1, 1'b1, 16'sh0000, 16'sh0D20};
    vecs[3] = '{12'hFFF, 1'b1, 1'b0, 16'sh7FF0, 16'sh1B7A};
    vecs[4] = '{12'hFFF, 1'b0, 1'b0, 16'sh7FF0, 16'sh2808};
    vecs[5] = '{12'h000, 1'b0, 1'b0, 16'sh8000, 16'sh1307};
    vecs[6] = '{12'h000, 1'b1, 1'b0, 16'shC000, 16'sh08A6};

    // Reset state, then the idle sigma-delta pattern after release.
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst/pcm0", if0.pcm, 0);
    check("rst/valid0", if0.pcm_valid, 0);
    check("rst/dac0", dac0, 0);
    check("rst/pcm3", if3.pcm, 0);
    check("rst/dac3", dac3, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("idle/dac0_%0d", k), dac0, k % 2);
      check($sformatf("idle/dac3_%0d", k), dac3, k % 2);
      check($sformatf("idle/valid0_%0d", k), if0.pcm_valid, 0);
    end

    // Table vectors, hand-computed from lp=0.
    for (int i = 0; i < 7; i++) begin
      run_sample(vecs[i].sound, vecs[i].snd, vecs[i].mute, $sformatf("vec%0d", i),
                 vecs[i].exp0, vecs[i].exp3);
      lp0_m = model_step(lp0_m, vecs[i].sound, vecs[i].snd, vecs[i].mute, 0);
      lp3_m = model_step(lp3_m, vecs[i].sound, vecs[i].snd, vecs[i].mute, 3);
    end

    // Four back-to-back strobes: only the first is accepted.
    drive(1'b1, 12'h800, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) drive(1'b0, 12'h800, 1'b1, 1'b0);
      if (if0.pcm_valid) c0++;
    end
    c0 = 0; c3 = 0;
    drive(1'b1, 12'h800, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) drive(1'b0, 12'h800, 1'b1, 1'b0);
      if (if0.pcm_valid) c0++;
      if (if3.pcm_valid) c3++;
    end
    check("burst/pulses0", c0, 1);
    check("burst/pulses3", c3, 1);
    // Earlier loop above also accepted one sample (strobe held 3 cycles).
    lp0_m = model_step(lp0_m, 12'h800, 1'b1, 1'b0, 0);
    lp3_m = model_step(lp3_m, 12'h800, 1'b1, 1'b0, 3);
    lp0_m = model_step(lp0_m, 12'h800, 1'b1, 1'b0, 0);
    lp3_m = model_step(lp3_m, 12'h800, 1'b1, 1'b0, 3);
    check("burst/pcm0", if0.pcm, lp0_m);
    check("burst/pcm3", if3.pcm, lp3_m);

    // Strobe at E0 and again at E4: both accepted.
    drive(1'b1, 12'h000, 1'b1, 1'b0);
    c0 = 0; c3 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 12'h000, 1'b1, 1'b0);
      if (c == 4) drive(1'b1, 12'h000, 1'b1, 1'b0);
      if (c == 5) drive(1'b0, 12'h000, 1'b1, 1'b0);
      if (if0.pcm_valid) c0++;
      if (if3.pcm_valid) c3++;
    end
    check("spaced/pulses0", c0, 2);
    check("spaced/pulses3", c3, 2);
    for (int k = 0; k < 2; k++) begin
      lp0_m = model_step(lp0_m, 12'h000, 1'b1, 1'b0, 0);
      lp3_m = model_step(lp3_m, 12'h000, 1'b1, 1'b0, 3);
    end
    check("spaced/pcm0", if0.pcm, lp0_m);
    check("spaced/pcm3", if3.pcm, lp3_m);

    // Reset while the sample sits in FILT: no pulse, everything cleared.
    drive(1'b1, 12'h800, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 12'h800, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst/pcm0", if0.pcm, 0);
    check("midrst/pcm3", if3.pcm, 0);
    check("midrst/valid0", if0.pcm_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    lp0_m = 0;
    lp3_m = 0;
    count_pulses(5, c0, c3);
    check("midrst/no_pulse0", c0, 0);
    check("midrst/no_pulse3", c3, 0);
    run_sample(12'h800, 1'b1, 1'b0, "post_rst", 16'sh4000, 16'sh0800);
    lp0_m = model_step(lp0_m, 12'h800, 1'b1, 1'b0, 0);
    lp3_m = model_step(lp3_m, 12'h800, 1'b1, 1'b0, 3);

    // Randomised samples against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [11:0] s;
      logic sn, m;
      int e0, e3;
      s  = 12'($urandom);
      sn = 1'($urandom);
      m  = ($urandom_range(0, 3) == 0);
      e0 = model_step(lp0_m, s, sn, m, 0);
      e3 = model_step(lp3_m, s, sn, m, 3);
      run_sample(s, sn, m, $sformatf("rnd%0d", i), e0, e3);
      lp0_m = e0;
      lp3_m = e3;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Sigma-delta density with a steady pcm value.
    repeat (4) @(negedge clk);
    ones = 0;
    for (int c = 0; c < 2048; c++) begin
      @(negedge clk);
      if (dac0) ones++;
    end
    expd = (lp0_m + 32768) / 32;
    n_checks++;
    if (ones < expd - 2 || ones > expd + 2) begin
      n_errors++;
      $display("FAIL dac_density: got %0d ones expected %0d", ones, expd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trs80_audio_out.md
# trs80_audio_out

Audio back-end stage directly downstream of the CoCo sound-select/DAC block. It samples the selected 12-bit sound word plus the 1-bit sound line on a sample strobe, mixes and saturates them, and applies a one-pole low-pass IIR. It presents a signed 16-bit PCM sample to the board audio path and also drives a first-order sigma-delta bitstream for a pin-level RC DAC.

## Interface
Parameters:
- FILTER_SHIFT, default 3: IIR coefficient as an arithmetic right-shift; 0 = filter bypass.
- SND_LEVEL, default 12'h400: unsigned amount added to the mix while `snd`=1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce_sample  in  1  one-cycle sample strobe.
- sound  in  12  unsigned selected sound word; 0 = silence floor, 2048 = midpoint.
- snd  in  1  1-bit sound line; not gated by sound enable.
- mute  in  1  forces the filter input to the midpoint.
- pcm  out  16  signed filtered sample.
- pcm_valid  out  1  one-cycle pulse when `pcm` updates.
- dac_out  out  1  sigma-delta bitstream.

## Operation
- FSM states: IDLE, MIX, FILT, OUT.
- IDLE:
  - If `ce_sample`=1, register `sound`, `snd` and `mute`, then go to MIX.
  - Otherwise stay in IDLE.
  - `ce_sample` in any other state is ignored and not queued.
- MIX:
  - mix = sound + (snd ? SND_LEVEL : 0), computed at 13 bits unsigned and saturated to 4095.
  - If mute, mix = 2048.
  - x = (mix − 2048) <<< 4, a 16-bit signed value in [−32768, 32752].
  - Go to FILT.
- FILT:
  - lp <= lp + ((x − lp) >>> FILTER_SHIFT).
  - The difference is computed at 17 bits signed; the result always fits in 16 bits.
  - Go to OUT.
- OUT:
  - pcm <= lp; pcm_valid <= 1.
  - Go to IDLE.
  - pcm_valid is cleared on the next edge.
- Sigma-delta runs every clk, independent of the FSM:
  - {carry, acc} <= acc + (pcm ^ 16'h8000), where acc is 16 bits.
  - dac_out <= carry.
  - Output density = (pcm + 32768) / 65536.
- Reset values: state IDLE; lp, acc, pcm, the input registers, pcm_valid and dac_out all 0.
- Reset asserted mid-operation: the in-flight sample is discarded and no pcm_valid pulse is produced. The first sample after release starts from lp=0.

## Timing
- Latency: `ce_sample` sampled at edge E0 (state IDLE) → pcm and pcm_valid updated at edge E3. pcm_valid is high for exactly the cycle between E3 and E4.
- Minimum strobe spacing is 4 clocks. A strobe at E1, E2 or E3 is dropped.
- `sound`, `snd` and `mute` are only sampled at the accepting edge; later changes do not affect the in-flight sample.
- A new pcm value reaches the sigma-delta adder at the edge after E3.
- There is no combinational path from any input to any output.

## Structure
- Package trs80_audio_pkg:
  - state enum (IDLE, MIX, FILT, OUT);
  - MID = 12'd2048;
  - default SND_LEVEL constant.
- Sub-module trs80_sigma_delta:
  - inputs clk, reset_n, 16-bit signed pcm;
  - output dac_out;
  - owns acc.
- The top level holds the FSM, the mix/saturation logic and the IIR.

## Test plan
- Reset, then idle with no strobes → pcm=0, pcm_valid=0, dac_out=0 after reset. After release dac_out toggles 0,1,0,1…
- FILTER_SHIFT=0, sound=4095, snd=0, strobe at E0 → pcm_valid only in the cycle after E3, pcm=16'h7FF0.
- FILTER_SHIFT=0, SND_LEVEL=12'h400:
  - sound=12'h800, snd=1 → pcm=16'h4000;
  - sound=4095, snd=1 → saturates, pcm=16'h7FF0.
- FILTER_SHIFT=3, x=16'h4000 twice from lp=0 → pcm 16'h0800, then 16'h0F00. Then mute=1 → 16'h0D20.
- Strobes on 4 consecutive cycles → exactly one pcm_valid pulse. A strobe 4 cycles after the first accepted one → a second pulse.
- reset_n low while in FILT → no pcm_valid pulse and pcm=0. The next sample of 12'h800 with snd=1 and FILTER_SHIFT=0 → pcm=16'h4000.
